// File: rtl/vc_output_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vc_output_pkg
// Purpose  : Shared types and helpers for the output-port VC state tracker.
//            Holds the per-VC state enum, the index/counter width helpers,
//            the bit positions inside the sticky error vector and the flit
//            type encodings (kept identical to the params.svh values).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vc_output_pkg;

  // Per-VC ownership state as seen by the output stage.
  typedef enum logic [1:0] {
    FREE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } vc_state_t;

  // Flit type encodings; these must track the values in params.svh.
  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;

  // Bit positions inside the sticky err vector {alloc_busy, overflow, underflow}.
  localparam int c_ERR_UNDERFLOW  = 0;
  localparam int c_ERR_OVERFLOW   = 1;
  localparam int c_ERR_ALLOC_BUSY = 2;

  // VC index width; a single-VC port still carries a 1-bit index.
  function automatic int vcw_of(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Credit counter width; must hold the value CREDIT_DEPTH itself.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : vc_output_pkg
`default_nettype wire

// File: rtl/vc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : vc_credit_counter
// Purpose  : One saturating downstream-credit counter for a single VC.
//            Resets to CREDIT_DEPTH (downstream buffer empty). A departing
//            flit consumes a credit, a returned credit restores one; both in
//            the same cycle cancel out. Attempts to go below zero or above
//            CREDIT_DEPTH hold the count and raise a one-cycle pulse.
// Ports    : clk, rstn        - clock, async active-low reset
//            i_dec            - flit departed on this VC
//            i_inc            - credit returned for this VC
//            o_cnt            - registered credit count
//            o_cnt_next       - count that will be loaded at the next edge
//            o_underflow      - pulse: departure while count == 0
//            o_overflow       - pulse: credit while count == CREDIT_DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module vc_credit_counter
  import vc_output_pkg::*;
#(
  parameter  int CREDIT_DEPTH = 4,
  localparam int CW           = cw_of(CREDIT_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_dec,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_next,
  output logic          o_underflow,
  output logic          o_overflow
);

  localparam logic [CW-1:0] c_FULL = CW'(CREDIT_DEPTH);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_underflow;
  logic          w_overflow;

  // Simultaneous dec and inc fall through to "hold" with no error, even at
  // either saturation point.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_underflow = 1'b0;
    w_overflow  = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_cnt == c_FULL) begin
        w_overflow = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else if (i_dec && !i_inc) begin
      if (r_cnt == '0) begin
        w_underflow = 1'b1;
      end else begin
        w_cnt_next = r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= c_FULL;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_cnt_next  = w_cnt_next;
  assign o_underflow = w_underflow;
  assign o_overflow  = w_overflow;

endmodule : vc_credit_counter
`default_nettype wire

// File: rtl/vc_output_state.sv
`default_nettype none
// ============================================================================
// Module   : vc_output_state
// Purpose  : Per-output-port virtual-channel state tracker. For every VC it
//            tracks ownership (FREE/BUSY/DRAIN) and the downstream credit
//            count, and presents vc_available / credit_avail to the VC and
//            switch allocators. All outputs come straight from flops.
// Ports    : clk, rstn        - clock, async active-low reset
//            flit_fire        - a flit leaves on the link this cycle
//            flit_vc          - VC of the departing flit
//            flit_type        - HEAD/BODY/TAIL of the departing flit
//            alloc_valid      - VC allocator claims alloc_vc this cycle
//            alloc_vc         - VC being claimed
//            credit_valid     - downstream returns a credit for credit_vc
//            credit_vc        - VC of the returned credit
//            vc_available     - per VC: state is FREE
//            credit_avail     - per VC: credit count nonzero
//            credit_cnt       - packed credit counts, VC0 in the LSBs
//            err              - sticky {alloc_busy, overflow, underflow}
// Config   : VC_ATOMIC_RELEASE_EN - when defined, a tail moves the VC to
//            DRAIN and it is only released once every credit is back, so a
//            downstream VC never holds flits of two packets. When undefined
//            a tail releases the VC directly and DRAIN is never entered.
// Revision : 1.0 - initial release
// ============================================================================
module vc_output_state
  import vc_output_pkg::*;
#(
  parameter  int NUM_VC       = 2,
  parameter  int CREDIT_DEPTH = 4,
  localparam int VCW          = vcw_of(NUM_VC),
  localparam int CW           = cw_of(CREDIT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flit_fire,
  input  logic [VCW-1:0]       flit_vc,
  input  logic [1:0]           flit_type,
  input  logic                 alloc_valid,
  input  logic [VCW-1:0]       alloc_vc,
  input  logic                 credit_valid,
  input  logic [VCW-1:0]       credit_vc,
  output logic [NUM_VC-1:0]    vc_available,
  output logic [NUM_VC-1:0]    credit_avail,
  output logic [NUM_VC*CW-1:0] credit_cnt,
  output logic [2:0]           err
);

`ifdef VC_ATOMIC_RELEASE_EN
  localparam logic [CW-1:0] c_FULL = CW'(CREDIT_DEPTH);
`endif

  logic [NUM_VC-1:0] w_under;
  logic [NUM_VC-1:0] w_over;
  logic [NUM_VC-1:0] w_alloc_err;
  logic [2:0]        w_err_set;
  logic [2:0]        r_err;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    // Index values >= NUM_VC never match any lane, so out-of-range events
    // are dropped without extra logic.
    localparam logic [VCW-1:0] c_IDX = VCW'(i);

    logic          w_fire;
    logic          w_tail;
    logic          w_alloc;
    logic          w_credit;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_next;
    vc_state_t     r_state;
    vc_state_t     w_state_next;
    logic          r_avail;
    logic          r_credit_avail;

    assign w_fire   = flit_fire    && (flit_vc   == c_IDX);
    assign w_tail   = w_fire       && (flit_type == TAIL);
    assign w_alloc  = alloc_valid  && (alloc_vc  == c_IDX);
    assign w_credit = credit_valid && (credit_vc == c_IDX);

    vc_credit_counter #(
      .CREDIT_DEPTH (CREDIT_DEPTH)
    ) u_credit (
      .clk         (clk),
      .rstn        (rstn),
      .i_dec       (w_fire),
      .i_inc       (w_credit),
      .o_cnt       (w_cnt),
      .o_cnt_next  (w_cnt_next),
      .o_underflow (w_under[i]),
      .o_overflow  (w_over[i])
    );

    // A claim only succeeds on a FREE VC with no tail in the same cycle;
    // the tail wins a same-cycle collision and the claim is reported.
    assign w_alloc_err[i] = w_alloc && ((r_state != FREE) || w_tail);

`ifdef VC_ATOMIC_RELEASE_EN
    // Release condition looks at the count being loaded this edge, so a
    // tail or a final credit that leaves the buffer empty frees the VC in
    // the same cycle.
    logic w_full_next;
    assign w_full_next = (w_cnt_next == c_FULL);
`endif

    always_comb begin
      w_state_next = r_state;
      case (r_state)
        FREE: begin
          if (w_alloc && !w_tail) begin
            w_state_next = BUSY;
          end
        end
        BUSY: begin
          if (w_tail) begin
`ifdef VC_ATOMIC_RELEASE_EN
            w_state_next = w_full_next ? FREE : DRAIN;
`else
            w_state_next = FREE;
`endif
          end
        end
        DRAIN: begin
`ifdef VC_ATOMIC_RELEASE_EN
          if (w_full_next) begin
            w_state_next = FREE;
          end
`else
          // Not reachable in this build; recover to FREE if ever entered.
          w_state_next = FREE;
`endif
        end
        default: begin
          w_state_next = FREE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_state        <= FREE;
        r_avail        <= 1'b1;
        r_credit_avail <= 1'b1;
      end else begin
        r_state        <= w_state_next;
        r_avail        <= (w_state_next == FREE);
        r_credit_avail <= (w_cnt_next != '0);
      end
    end

    assign vc_available[i]          = r_avail;
    assign credit_avail[i]          = r_credit_avail;
    assign credit_cnt[i*CW +: CW]   = w_cnt;
  end : g_vc

  assign w_err_set[c_ERR_UNDERFLOW]  = |w_under;
  assign w_err_set[c_ERR_OVERFLOW]   = |w_over;
  assign w_err_set[c_ERR_ALLOC_BUSY] = |w_alloc_err;

  // Sticky: flags only accumulate until the next reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 3'b000;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  assign err = r_err;

endmodule : vc_output_state
`default_nettype wire

// File: tb/tb_vc_output_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_output_state
// Purpose  : Self-checking bench for vc_output_state with NUM_VC=2 and
//            CREDIT_DEPTH=4. Directed steps cover the main scenarios and
//            boundary cases; a random phase is compared against a
//            behavioural model of VC ownership and credit accounting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_output_state;
  import vc_output_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flit_fire;
  logic [0:0] flit_vc;
  logic [1:0] flit_type;
  logic       alloc_valid;
  logic [0:0] alloc_vc;
  logic       credit_valid;
  logic [0:0] credit_vc;
  logic [1:0] vc_available;
  logic [1:0] credit_avail;
  logic [5:0] credit_cnt;
  logic [2:0] err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: credits outstanding downstream and who owns each VC.
  int   m_cnt   [2];
  bit   m_owned [2];   // claimed by a packet that has not sent its tail
  bit   m_drain [2];   // tail sent, waiting for downstream to empty
  logic [2:0] m_err;

  vc_output_state #(
    .NUM_VC       (2),
    .CREDIT_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flit_fire    (flit_fire),
    .flit_vc      (flit_vc),
    .flit_type    (flit_type),
    .alloc_valid  (alloc_valid),
    .alloc_vc     (alloc_vc),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .vc_available (vc_available),
    .credit_avail (credit_avail),
    .credit_cnt   (credit_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_cnt[v]   = DEPTH;
      m_owned[v] = 1'b0;
      m_drain[v] = 1'b0;
    end
    m_err = 3'b000;
  endtask

  task automatic model_update(input bit f, input int fv, input logic [1:0] ft,
                              input bit a, input int av, input bit c, input int cv);
    for (int v = 0; v < 2; v++) begin
      bit sent  = f && (fv == v);
      bit tail  = sent && (ft == TAIL);
      bit claim = a && (av == v);
      bit back  = c && (cv == v);
      bit idle  = !m_owned[v] && !m_drain[v];
      int n     = m_cnt[v];
      if (sent && !back) begin
        if (n == 0) m_err[0] = 1'b1;
        else n = n - 1;
      end else if (back && !sent) begin
        if (n == DEPTH) m_err[1] = 1'b1;
        else n = n + 1;
      end
      if (claim && (!idle || tail)) m_err[2] = 1'b1;
      if (m_owned[v] && tail) begin
        m_owned[v] = 1'b0;
`ifdef VC_ATOMIC_RELEASE_EN
        m_drain[v] = (n != DEPTH);
`endif
      end else if (m_drain[v]) begin
        if (n == DEPTH) m_drain[v] = 1'b0;
      end else if (idle && claim && !tail) begin
        m_owned[v] = 1'b1;
      end
      m_cnt[v] = n;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [1:0] e_av, e_ca;
    logic [5:0] e_cnt;
    for (int v = 0; v < 2; v++) begin
      e_av[v] = !m_owned[v] && !m_drain[v];
      e_ca[v] = (m_cnt[v] != 0);
    end
    e_cnt = {3'(m_cnt[1]), 3'(m_cnt[0])};
    chk({tag, " vc_available"}, 32'(vc_available), 32'(e_av));
    chk({tag, " credit_avail"}, 32'(credit_avail), 32'(e_ca));
    chk({tag, " credit_cnt"},   32'(credit_cnt),   32'(e_cnt));
    chk({tag, " err"},          32'(err),          32'(m_err));
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), let the edge
  // happen, advance the model and compare.
  task automatic step(input string tag, input bit f, input int fv, input logic [1:0] ft,
                      input bit a, input int av, input bit c, input int cv);
    flit_fire    = f;
    flit_vc      = 1'(fv);
    flit_type    = ft;
    alloc_valid  = a;
    alloc_vc     = 1'(av);
    credit_valid = c;
    credit_vc    = 1'(cv);
    @(posedge clk);
    model_update(f, fv, ft, a, av, c, cv);
    #1;
    compare_model(tag);
  endtask

  task automatic idle_inputs();
    flit_fire = 0; flit_vc = 0; flit_type = HEAD;
    alloc_valid = 0; alloc_vc = 0; credit_valid = 0; credit_vc = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " vc_available"}, 32'(vc_available), 32'h3);
    chk({tag, " credit_avail"}, 32'(credit_avail), 32'h3);
    chk({tag, " credit_cnt"},   32'(credit_cnt),   32'(6'b100_100));
    chk({tag, " err"},          32'(err),          32'h0);
  endtask

  int exp_fire_cnt [5] = '{3, 2, 1, 0, 0};
  int exp_fire_ca0 [5] = '{1, 1, 1, 0, 0};
  int exp_fire_e0  [5] = '{0, 0, 0, 0, 1};

  initial begin
    idle_inputs();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    model_reset();
    #20;
    check_reset_values("reset");
    @(posedge clk);
    #1 rstn = 1'b1;

    // Packet on VC1: alloc, HEAD, BODY, TAIL.
    step("alloc1", 0, 0, HEAD, 1, 1, 0, 0);
    chk("alloc1 avail", 32'(vc_available), 32'h1);
    step("head1", 1, 1, HEAD, 0, 0, 0, 0);
    step("body1", 1, 1, BODY, 0, 0, 0, 0);
    step("tail1", 1, 1, TAIL, 0, 0, 0, 0);
    chk("tail1 cnt1", 32'(credit_cnt[5:3]), 32'd1);
`ifdef VC_ATOMIC_RELEASE_EN
    chk("tail1 avail", 32'(vc_available), 32'h1);
`else
    chk("tail1 avail", 32'(vc_available), 32'h3);
`endif
    step("cred1a", 0, 0, HEAD, 0, 0, 1, 1);
    step("cred1b", 0, 0, HEAD, 0, 0, 1, 1);
`ifdef VC_ATOMIC_RELEASE_EN
    chk("cred1b avail", 32'(vc_available), 32'h1);
`endif
    step("cred1c", 0, 0, HEAD, 0, 0, 1, 1);
    chk("cred1c avail", 32'(vc_available), 32'h3);
    chk("cred1c cnt1", 32'(credit_cnt[5:3]), 32'd4);

    // Five fires on VC0 with no credits returned.
    for (int k = 0; k < 5; k++) begin
      step("fire0", 1, 0, BODY, 0, 0, 0, 0);
      chk("fire0 cnt0", 32'(credit_cnt[2:0]), 32'(exp_fire_cnt[k]));
      chk("fire0 cavail0", 32'(credit_avail[0]), 32'(exp_fire_ca0[k]));
      chk("fire0 err0", 32'(err[0]), 32'(exp_fire_e0[k]));
    end

    // Bring VC0 to 2, then fire and credit together.
    step("cred0a", 0, 0, HEAD, 0, 0, 1, 0);
    step("cred0b", 0, 0, HEAD, 0, 0, 1, 0);
    step("firecred0", 1, 0, BODY, 0, 0, 1, 0);
    chk("firecred0 cnt0", 32'(credit_cnt[2:0]), 32'd2);
    chk("firecred0 err", 32'(err), 32'h1);

    // Overflowing credit on full VC1, flag stays set.
    step("ovf1", 0, 0, HEAD, 0, 0, 1, 1);
    chk("ovf1 cnt1", 32'(credit_cnt[5:3]), 32'd4);
    chk("ovf1 err", 32'(err), 32'h3);
    step("idle", 0, 0, HEAD, 0, 0, 0, 0);
    chk("idle err sticky", 32'(err), 32'h3);

    // Alloc colliding with the tail on BUSY VC0.
    step("alloc0", 0, 0, HEAD, 1, 0, 0, 0);
    chk("alloc0 avail", 32'(vc_available), 32'h2);
    step("alloctail0", 1, 0, TAIL, 1, 0, 0, 0);
`ifdef VC_ATOMIC_RELEASE_EN
    chk("alloctail0 avail", 32'(vc_available), 32'h2);
`else
    chk("alloctail0 avail", 32'(vc_available), 32'h3);
`endif
    chk("alloctail0 err", 32'(err), 32'h7);

    // Asynchronous reset in the middle of a packet.
    step("alloc1r", 0, 0, HEAD, 1, 1, 0, 0);
    step("head1r", 1, 1, HEAD, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;

    // Random traffic against the model, with one more mid-run reset.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        #2 rstn = 1'b0;
        #1;
        check_reset_values("rndreset");
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
      end
      step("rand",
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           2'($urandom_range(0, 2)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vc_output_state
`default_nettype wire
